// File: rtl/matrix_tx_scheduler_if.sv
// Strobe/flit bus between the CPU MMIO output registers and the scheduler.
// master drives the strobes and credit_return and receives flits. slave is the scheduler.
interface matrix_tx_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int POS_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0]             in_matrix;
    logic                              in_matrix_en;
    logic                              in_end_row;
    logic                              in_end;
    logic [POS_WIDTH-1:0]              in_position;
    logic                              in_position_en;
    logic                              credit_return;
    logic                              flit_valid;
    logic [2+POS_WIDTH+DATA_WIDTH-1:0] flit_out;

    modport master (
        output in_matrix, in_matrix_en, in_end_row, in_end,
        output in_position, in_position_en, credit_return,
        input  flit_valid, flit_out
    );

    modport slave (
        input  in_matrix, in_matrix_en, in_end_row, in_end,
        input  in_position, in_position_en, credit_return,
        output flit_valid, flit_out
    );
endinterface

// File: rtl/matrix_tx_scheduler.sv
// Matrix TX scheduler: queues CPU matrix strobes in a FIFO and issues them
// as credit-flow-controlled flits {type, dest, payload} toward the NoC router.
// Ports: clk, reset (sync, active-high), bus (slave: strobes, credit_return,
//   flit_valid, flit_out), clear_flags, status outputs fifo_count, fifo_full, busy,
//   overflow, protocol_err, credit_err and drop_count.
module matrix_tx_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int POS_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    matrix_tx_scheduler_if.slave         bus,
    input  logic                         clear_flags,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         fifo_full,
    output logic                         busy,
    output logic                         overflow,
    output logic                         protocol_err,
    output logic                         credit_err,
    output logic [7:0]                   drop_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = 2 + DATA_WIDTH;
    localparam int FW  = 2 + POS_WIDTH + DATA_WIDTH;
    localparam int CRW = $clog2(MAX_CREDITS + 1);

    localparam logic [1:0] K_DATA = 2'b00;
    localparam logic [1:0] K_ROW  = 2'b01;
    localparam logic [1:0] K_END  = 2'b10;
    localparam logic [1:0] K_POS  = 2'b11;

    localparam logic [CRW-1:0] CR_MAX = CRW'(MAX_CREDITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [EW-1:0]         r_head;
    logic [POS_WIDTH-1:0]  r_dest;
    logic [CRW-1:0]        r_credits;
    logic [FW-1:0]         r_flit;
    logic                  r_overflow;
    logic                  r_perr;
    logic                  r_cerr;
    logic [7:0]            r_drop;

    logic [1:0]            w_kind;
    logic [DATA_WIDTH-1:0] w_val;
    logic [2:0]            w_nstb;
    logic [2:0]            w_drops;
    logic                  w_any;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_set_dest;
    logic [FW-1:0]         w_flit;
    logic [8:0]            w_drop_sum;
    logic [7:0]            w_drop_base;

    assign w_full = (r_count == CW'(FIFO_DEPTH));

    // Strobe arbitration: the winner is enqueued, every loser counts as a drop.
    always_comb begin
        w_kind = K_DATA;
        w_val  = '0;
        if (bus.in_position_en) begin
            w_kind                 = K_POS;
            w_val[POS_WIDTH-1:0]   = bus.in_position;
        end else if (bus.in_matrix_en) begin
            w_kind = K_DATA;
            w_val  = bus.in_matrix;
        end else if (bus.in_end_row) begin
            w_kind = K_ROW;
        end else if (bus.in_end) begin
            w_kind = K_END;
        end
    end

    assign w_nstb = {2'b00, bus.in_position_en} + {2'b00, bus.in_matrix_en}
                  + {2'b00, bus.in_end_row} + {2'b00, bus.in_end};
    assign w_any  = (w_nstb != 3'd0);
    // Full is judged on the registered count; a same-cycle pop does not make room.
    assign w_wr   = w_any && !w_full && !reset;

    always_comb begin
        w_drops = 3'd0;
        if (w_full)
            w_drops = w_nstb;
        else if (w_nstb > 3'd1)
            w_drops = w_nstb - 3'd1;
    end

    assign w_drop_base = clear_flags ? 8'd0 : r_drop;
    assign w_drop_sum  = {1'b0, w_drop_base} + {6'd0, w_drops};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_FETCH;
            S_FETCH: w_next = (r_head[EW-1 -: 2] == K_POS) ? S_IDLE : S_ISSUE;
            S_ISSUE: if (r_credits != '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_pop      = 1'b0;
        w_set_dest = 1'b0;
        w_issue    = 1'b0;
        unique case (r_state)
            S_IDLE:  w_pop      = (r_count != '0) && !reset;
            S_FETCH: w_set_dest = (r_head[EW-1 -: 2] == K_POS);
            S_ISSUE: w_issue    = (r_credits != '0) && !reset;
            default: ;
        endcase
    end

    assign w_flit = {r_head[EW-1 -: 2], r_dest, r_head[DATA_WIDTH-1:0]};

    assign bus.flit_valid = w_issue;
    // Between strobes the last issued flit stays visible.
    assign bus.flit_out   = w_issue ? w_flit : r_flit;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {w_kind, w_val};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_dest     <= '0;
            r_credits  <= CR_MAX;
            r_flit     <= '0;
            r_overflow <= 1'b0;
            r_perr     <= 1'b0;
            r_cerr     <= 1'b0;
            r_drop     <= 8'd0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_set_dest)
                r_dest <= r_head[POS_WIDTH-1:0];
            if (w_issue)
                r_flit <= w_flit;
            if (w_issue && !bus.credit_return)
                r_credits <= r_credits - CRW'(1);
            else if (!w_issue && bus.credit_return && r_credits != CR_MAX)
                r_credits <= r_credits + CRW'(1);
            // Clear loses to an error raised in the same cycle.
            r_overflow <= (r_overflow && !clear_flags) || (w_any && w_full);
            r_perr     <= (r_perr && !clear_flags) || (w_nstb > 3'd1);
            r_cerr     <= (r_cerr && !clear_flags)
                       || (bus.credit_return && r_credits == CR_MAX);
            r_drop     <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign fifo_count   = r_count;
    assign fifo_full    = w_full;
    assign busy         = (r_count != '0) || (r_state != S_IDLE);
    assign overflow     = r_overflow;
    assign protocol_err = r_perr;
    assign credit_err   = r_cerr;
    assign drop_count   = r_drop;
endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Directed testbench for matrix_tx_scheduler.
// Flits are captured by a monitor with their cycle number; each test checks inline.
module tb_matrix_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear_flags;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        busy;
    logic        overflow;
    logic        protocol_err;
    logic        credit_err;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [25:0] q_flit[$];
    int          q_cyc[$];

    matrix_tx_scheduler_if #(.DATA_WIDTH(16), .POS_WIDTH(8)) intf ();

    matrix_tx_scheduler #(
        .DATA_WIDTH(16), .POS_WIDTH(8), .FIFO_DEPTH(16), .MAX_CREDITS(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (intf.slave),
        .clear_flags  (clear_flags),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .overflow     (overflow),
        .protocol_err (protocol_err),
        .credit_err   (credit_err),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (intf.flit_valid) begin
            q_flit.push_back(intf.flit_out);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        intf.in_matrix      = '0;
        intf.in_matrix_en   = 1'b0;
        intf.in_end_row     = 1'b0;
        intf.in_end         = 1'b0;
        intf.in_position    = '0;
        intf.in_position_en = 1'b0;
        intf.credit_return  = 1'b0;
        clear_flags         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q_flit.delete();
        q_cyc.delete();
    endtask

    task automatic send_data(input logic [15:0] v);
        intf.in_matrix    = v;
        intf.in_matrix_en = 1'b1;
        tick();
        intf.in_matrix_en = 1'b0;
    endtask

    task automatic send_pos(input logic [7:0] p);
        intf.in_position    = p;
        intf.in_position_en = 1'b1;
        tick();
        intf.in_position_en = 1'b0;
    endtask

    task automatic send_credit();
        intf.credit_return = 1'b1;
        tick();
        intf.credit_return = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        for (int i = 0; i < budget && q_flit.size() < n; i++)
            tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", fifo_count);
        end
        total++;
        if ({fifo_full, busy, overflow, protocol_err, credit_err, intf.flit_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {fifo_full, busy, overflow, protocol_err, credit_err, intf.flit_valid});
        end
        total++;
        if (drop_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_drop got=%0d want=0", drop_count);
        end
        total++;
        if (intf.flit_out !== 26'd0) begin
            bad++;
            $display("FAIL reset_flit_out got=%h want=0", intf.flit_out);
        end
    endtask

    task automatic test_basic();
        int p;
        do_reset();
        p = cyc;
        send_pos(8'h05);
        send_data(16'h1234);
        intf.in_end_row = 1'b1;
        tick();
        intf.in_end_row = 1'b0;
        intf.in_end = 1'b1;
        tick();
        intf.in_end = 1'b0;
        wait_q(3, 40);
        total++;
        if (q_flit.size() !== 3) begin
            bad++;
            $display("FAIL basic_count got=%0d want=3", q_flit.size());
        end else begin
            total++;
            if (q_flit[0] !== {2'b00, 8'h05, 16'h1234}) begin
                bad++;
                $display("FAIL basic_flit0 got=%h want=%h", q_flit[0], {2'b00, 8'h05, 16'h1234});
            end
            total++;
            if (q_flit[1] !== {2'b01, 8'h05, 16'h0000}) begin
                bad++;
                $display("FAIL basic_flit1 got=%h want=%h", q_flit[1], {2'b01, 8'h05, 16'h0000});
            end
            total++;
            if (q_flit[2] !== {2'b10, 8'h05, 16'h0000}) begin
                bad++;
                $display("FAIL basic_flit2 got=%h want=%h", q_flit[2], {2'b10, 8'h05, 16'h0000});
            end
            total++;
            if (q_cyc[0] !== p + 5) begin
                bad++;
                $display("FAIL basic_first_cycle got=%0d want=%0d", q_cyc[0], p + 5);
            end
            total++;
            if (q_cyc[1] !== p + 8) begin
                bad++;
                $display("FAIL basic_rate got=%0d want=%0d", q_cyc[1], p + 8);
            end
        end
        total++;
        if (intf.flit_out !== {2'b10, 8'h05, 16'h0000}) begin
            bad++;
            $display("FAIL basic_hold got=%h want=%h", intf.flit_out, {2'b10, 8'h05, 16'h0000});
        end
    endtask

    task automatic test_credits();
        int k;
        do_reset();
        for (int i = 0; i < 6; i++)
            send_data(16'h0100 + 16'(i));
        repeat (40) tick();
        total++;
        if (q_flit.size() !== 4) begin
            bad++;
            $display("FAIL credit_limit got=%0d want=4", q_flit.size());
        end
        total++;
        if ({busy, intf.flit_valid, fifo_count} !== {1'b1, 1'b0, 5'd1}) begin
            bad++;
            $display("FAIL credit_hold busy/valid/count got=%b/%b/%0d want=1/0/1",
                     busy, intf.flit_valid, fifo_count);
        end
        k = cyc;
        send_credit();
        repeat (10) tick();
        total++;
        if (q_flit.size() !== 5) begin
            bad++;
            $display("FAIL credit_resume_count got=%0d want=5", q_flit.size());
        end else begin
            total++;
            if (q_flit[4] !== {2'b00, 8'h00, 16'h0104} || q_cyc[4] !== k + 1) begin
                bad++;
                $display("FAIL credit_resume got=%h@%0d want=%h@%0d",
                         q_flit[4], q_cyc[4], {2'b00, 8'h00, 16'h0104}, k + 1);
            end
        end
    endtask

    task automatic test_overflow();
        logic [25:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++)
            send_data(16'h00AA);
        wait_q(4, 40);
        repeat (5) tick();
        q_flit.delete();
        q_cyc.delete();
        // One entry sits in the head register, so the 18th strobe finds the FIFO full.
        for (int i = 0; i < 18; i++)
            send_data(16'h0200 + 16'(i));
        total++;
        if ({fifo_full, overflow, fifo_count, drop_count} !== {1'b1, 1'b1, 5'd16, 8'd1}) begin
            bad++;
            $display("FAIL ovf_state full/ovf/count/drop got=%b/%b/%0d/%0d want=1/1/16/1",
                     fifo_full, overflow, fifo_count, drop_count);
        end
        for (int i = 0; i < 17; i++) begin
            send_credit();
            wait_q(i + 1, 20);
        end
        repeat (5) tick();
        total++;
        if (q_flit.size() !== 17) begin
            bad++;
            $display("FAIL ovf_drain_count got=%0d want=17", q_flit.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                exp = {2'b00, 8'h00, 16'h0200 + 16'(i)};
                total++;
                if (q_flit[i] !== exp) begin
                    bad++;
                    $display("FAIL ovf_order[%0d] got=%h want=%h", i, q_flit[i], exp);
                end
            end
        end
        total++;
        if ({fifo_count, busy, credit_err} !== {5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ovf_end count/busy/cerr got=%0d/%b/%b want=0/0/0",
                     fifo_count, busy, credit_err);
        end
    endtask

    task automatic test_protocol();
        int k;
        do_reset();
        k = cyc;
        intf.in_matrix    = 16'h0ABC;
        intf.in_matrix_en = 1'b1;
        intf.in_end_row   = 1'b1;
        tick();
        intf.in_matrix_en = 1'b0;
        intf.in_end_row   = 1'b0;
        total++;
        if ({protocol_err, overflow, drop_count} !== {1'b1, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL proto_flags perr/ovf/drop got=%b/%b/%0d want=1/0/1",
                     protocol_err, overflow, drop_count);
        end
        wait_q(1, 20);
        repeat (10) tick();
        total++;
        if (q_flit.size() !== 1) begin
            bad++;
            $display("FAIL proto_count got=%0d want=1", q_flit.size());
        end else begin
            total++;
            if (q_flit[0] !== {2'b00, 8'h00, 16'h0ABC} || q_cyc[0] !== k + 3) begin
                bad++;
                $display("FAIL proto_flit_latency got=%h@%0d want=%h@%0d",
                         q_flit[0], q_cyc[0], {2'b00, 8'h00, 16'h0ABC}, k + 3);
            end
        end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        total++;
        if ({protocol_err, drop_count} !== {1'b0, 8'd0}) begin
            bad++;
            $display("FAIL proto_clear perr/drop got=%b/%0d want=0/0", protocol_err, drop_count);
        end
        clear_flags         = 1'b1;
        intf.in_position    = 8'h09;
        intf.in_position_en = 1'b1;
        intf.in_end         = 1'b1;
        tick();
        idle_inputs();
        total++;
        if ({protocol_err, drop_count} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL proto_clear_race perr/drop got=%b/%0d want=1/1", protocol_err, drop_count);
        end
    endtask

    task automatic test_credit_err();
        do_reset();
        send_credit();
        total++;
        if (credit_err !== 1'b1) begin
            bad++;
            $display("FAIL cerr_set got=%b want=1", credit_err);
        end
        for (int i = 0; i < 5; i++)
            send_data(16'h0050 + 16'(i));
        repeat (40) tick();
        total++;
        if (q_flit.size() !== 4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cerr_credits flits/busy got=%0d/%b want=4/1", q_flit.size(), busy);
        end else begin
            total++;
            if (q_flit[3] !== {2'b00, 8'h00, 16'h0053}) begin
                bad++;
                $display("FAIL cerr_last got=%h want=%h", q_flit[3], {2'b00, 8'h00, 16'h0053});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pos(8'h33);
        for (int i = 0; i < 4; i++)
            send_data(16'h0010 + 16'(i));
        wait_q(4, 40);
        for (int i = 0; i < 6; i++)
            send_data(16'h0020 + 16'(i));
        repeat (10) tick();
        total++;
        if ({fifo_count, busy} !== {5'd5, 1'b1} || q_flit.size() !== 4) begin
            bad++;
            $display("FAIL mid_setup count/busy/flits got=%0d/%b/%0d want=5/1/4",
                     fifo_count, busy, q_flit.size());
        end else begin
            total++;
            if (q_flit[0] !== {2'b00, 8'h33, 16'h0010}) begin
                bad++;
                $display("FAIL mid_dest got=%h want=%h", q_flit[0], {2'b00, 8'h33, 16'h0010});
            end
        end
        q_flit.delete();
        q_cyc.delete();
        reset             = 1'b1;
        intf.in_matrix    = 16'h0F0F;
        intf.in_matrix_en = 1'b1;
        tick();
        reset             = 1'b0;
        intf.in_matrix_en = 1'b0;
        total++;
        if ({fifo_count, busy, intf.flit_valid, intf.flit_out} !== {5'd0, 1'b0, 1'b0, 26'd0}) begin
            bad++;
            $display("FAIL mid_reset count/busy/valid/out got=%0d/%b/%b/%h want=0/0/0/0",
                     fifo_count, busy, intf.flit_valid, intf.flit_out);
        end
        repeat (15) tick();
        total++;
        if (q_flit.size() !== 0) begin
            bad++;
            $display("FAIL mid_no_flit got=%0d want=0", q_flit.size());
        end
        for (int i = 0; i < 5; i++)
            send_data(16'h0060 + 16'(i));
        repeat (40) tick();
        total++;
        if (q_flit.size() !== 4) begin
            bad++;
            $display("FAIL mid_credits got=%0d want=4", q_flit.size());
        end else begin
            total++;
            if (q_flit[0] !== {2'b00, 8'h00, 16'h0060}) begin
                bad++;
                $display("FAIL mid_dest_cleared got=%h want=%h", q_flit[0], {2'b00, 8'h00, 16'h0060});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_credits();
        test_overflow();
        test_protocol();
        test_credit_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
